// File: rtl/rot_sweep_driver.sv
// rot_sweep_driver: feeds a 4-bit word and rotate amount to the downstream
// rotator. It either sweeps the amount through 0..3 or holds one amount,
// keeping each amount for DWELL cycles. On the last cycle of each dwell it
// checks the rotator's returned value against a rotate-right reference.
module rot_sweep_driver #(
    parameter int DWELL = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_mode,
    input  logic [1:0] in_sel,
    output logic [3:0] q,
    output logic [1:0] sel,
    output logic       q_valid,
    input  logic [3:0] rot_in,
    input  logic       err_clr,
    output logic       done,
    output logic       err,
    output logic [3:0] err_cnt
);

    // The dwell counter only has to reach DWELL-1.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      q_reg, q_next;
    logic [1:0]      sel_reg, sel_next;
    logic            mode_reg, mode_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            q_valid_reg, q_valid_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic [3:0]      err_cnt_reg, err_cnt_next;
    logic            sample;
    logic            mismatch;
    logic [3:0]      expected;

    // Reference rotate-right of the word currently driven to the rotator.
    always_comb begin
        expected = q_reg;
        case (sel_reg)
            2'd0:    expected = q_reg;
            2'd1:    expected = {q_reg[0],   q_reg[3:1]};
            2'd2:    expected = {q_reg[1:0], q_reg[3:2]};
            default: expected = {q_reg[2:0], q_reg[3]};
        endcase
    end

    // Next-state and next-output decode for the request sequencer.
    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        sel_next     = sel_reg;
        mode_next    = mode_reg;
        cnt_next     = cnt_reg;
        q_valid_next = 1'b0;
        done_next    = 1'b0;
        sample       = 1'b0;

        case (state_reg)
            IDLE: begin
                // in_ready is high in IDLE, so in_valid alone is a handshake.
                if (in_valid) begin
                    q_next       = in_data;
                    mode_next    = in_mode;
                    sel_next     = in_mode ? in_sel : 2'd0;
                    cnt_next     = '0;
                    q_valid_next = 1'b1;
                    state_next   = DRIVE;
                end
            end
            DRIVE: begin
                q_valid_next = 1'b1;
                cnt_next     = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    // Last dwell cycle: the rotator has had DWELL-1 cycles to settle.
                    sample = 1'b1;
                    if (mode_reg || (sel_reg == 2'd3)) begin
                        q_valid_next = 1'b0;
                        done_next    = 1'b1;
                        state_next   = DONE;
                    end else begin
                        sel_next = sel_reg + 2'd1;
                        cnt_next = '0;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Error tracking: a mismatch takes priority over a simultaneous clear,
    // so the count restarts at 1 rather than being lost.
    always_comb begin
        mismatch     = sample && (rot_in != expected);
        err_next     = err_reg;
        err_cnt_next = err_cnt_reg;
        if (mismatch) begin
            err_next = 1'b1;
            if (err_clr) begin
                err_cnt_next = 4'd1;
            end else if (err_cnt_reg != 4'd15) begin
                err_cnt_next = err_cnt_reg + 4'd1;
            end
        end else if (err_clr) begin
            err_next     = 1'b0;
            err_cnt_next = 4'd0;
        end
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            q_reg       <= 4'd0;
            sel_reg     <= 2'd0;
            mode_reg    <= 1'b0;
            cnt_reg     <= '0;
            q_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            sel_reg     <= sel_next;
            mode_reg    <= mode_next;
            cnt_reg     <= cnt_next;
            q_valid_reg <= q_valid_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign in_ready = (state_reg == IDLE);
    assign q        = q_reg;
    assign sel      = sel_reg;
    assign q_valid  = q_valid_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_rot_sweep_driver.sv
// Directed bench for rot_sweep_driver with a behavioural rotator in the
// feedback path that can be overridden to inject mismatches.
module tb_rot_sweep_driver;

    localparam int D = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_mode;
    logic [1:0] in_sel;
    logic [3:0] q;
    logic [1:0] sel;
    logic       q_valid;
    logic [3:0] rot_in;
    logic       err_clr;
    logic       done;
    logic       err;
    logic [3:0] err_cnt;

    logic       fault_en;
    logic [3:0] fault_val;
    logic [7:0] dbl;

    int checks   = 0;
    int failures = 0;

    rot_sweep_driver #(.DWELL(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_sel   (in_sel),
        .q        (q),
        .sel      (sel),
        .q_valid  (q_valid),
        .rot_in   (rot_in),
        .err_clr  (err_clr),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rotator model: rotate right by shifting a doubled copy of the word.
    always_comb begin
        dbl    = {q, q} >> sel;
        rot_in = fault_en ? fault_val : dbl[3:0];
    end

    // Present one request at a negedge; returns just after the accepting edge.
    task automatic start_req(input logic [3:0] d, input logic m, input logic [1:0] s);
        @(negedge clk);
        in_data  = d;
        in_mode  = m;
        in_sel   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom_range(0, 15));
            in_mode   = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            fault_en  = 1'($urandom_range(0, 1));
            fault_val = 4'($urandom_range(0, 15));
            err_clr   = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({q, sel, q_valid, done, err, err_cnt, in_ready} !== {4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_async: got q=%b sel=%0d qv=%b done=%b err=%b cnt=%0d rdy=%b want all zero, rdy=1",
                     q, sel, q_valid, done, err, err_cnt, in_ready);
        end
        in_valid = 1'b0; in_data = 4'd0; in_mode = 1'b0; in_sel = 2'd0;
        fault_en = 1'b0; fault_val = 4'd0; err_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: q=%b sel=%0d err_cnt=%0d in_ready=%b", q, sel, err_cnt, in_ready);
    endtask

    task automatic test_sweep(input logic [3:0] d);
        logic [1:0] es;
        start_req(d, 1'b0, 2'd3);
        for (int k = 1; k <= 4 * D + 2; k++) begin
            @(negedge clk);
            es = (k <= 4 * D) ? 2'((k - 1) / D) : 2'd3;
            checks++;
            if ({q_valid, done, in_ready, sel, q} !== {(k <= 4 * D), (k == 4 * D + 1), (k == 4 * D + 2), es, d}) begin
                failures++;
                $display("FAIL sweep_cycle%0d: got qv=%b done=%b rdy=%b sel=%0d q=%b want qv=%b done=%b rdy=%b sel=%0d q=%b",
                         k, q_valid, done, in_ready, sel, q, (k <= 4 * D), (k == 4 * D + 1), (k == 4 * D + 2), es, d);
            end
        end
        checks++;
        if ({err, err_cnt} !== 5'd0) begin
            failures++;
            $display("FAIL sweep_err: got err=%b cnt=%0d want 0/0", err, err_cnt);
        end
        $display("sweep: data=%b err=%b err_cnt=%0d", d, err, err_cnt);
    endtask

    task automatic test_single();
        start_req(4'b0110, 1'b1, 2'd2);
        for (int k = 1; k <= D + 2; k++) begin
            @(negedge clk);
            checks++;
            if ({q_valid, done, in_ready, sel, q} !== {(k <= D), (k == D + 1), (k == D + 2), 2'd2, 4'b0110}) begin
                failures++;
                $display("FAIL single_cycle%0d: got qv=%b done=%b rdy=%b sel=%0d q=%b want qv=%b done=%b rdy=%b sel=2 q=0110",
                         k, q_valid, done, in_ready, sel, q, (k <= D), (k == D + 1), (k == D + 2));
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL single_err: got err=%b want 0", err);
        end
        $display("single: data=0110 sel=2 err=%b", err);
    endtask

    task automatic test_fault_saturate();
        logic [3:0] before_cnt;
        logic [3:0] after_cnt;
        fault_en  = 1'b1;
        fault_val = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            before_cnt = (i < 15) ? 4'(i) : 4'd15;
            after_cnt  = (i < 14) ? 4'(i + 1) : 4'd15;
            start_req(4'b0001, 1'b1, 2'd1);
            repeat (D) @(negedge clk);
            checks++;
            if ({err, err_cnt} !== {(i != 0), before_cnt}) begin
                failures++;
                $display("FAIL fault_pre%0d: got err=%b cnt=%0d want err=%b cnt=%0d",
                         i, err, err_cnt, (i != 0), before_cnt);
            end
            @(negedge clk);
            checks++;
            if ({done, err, err_cnt} !== {1'b1, 1'b1, after_cnt}) begin
                failures++;
                $display("FAIL fault_post%0d: got done=%b err=%b cnt=%0d want done=1 err=1 cnt=%0d",
                         i, done, err, err_cnt, after_cnt);
            end
            $display("fault req %0d: err=%b err_cnt=%0d", i, err, err_cnt);
        end
        fault_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_collisions();
        // in_valid held through DRIVE with a different word on in_data.
        @(negedge clk);
        in_data = 4'b1100; in_mode = 1'b1; in_sel = 2'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_data = 4'b0011;
        for (int k = 1; k <= D + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, q, sel, done} !== {1'b0, 4'b1100, 2'd3, (k == D + 1)}) begin
                failures++;
                $display("FAIL hold_valid%0d: got rdy=%b q=%b sel=%0d done=%b want rdy=0 q=1100 sel=3 done=%b",
                         k, in_ready, q, sel, done, (k == D + 1));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, q_valid, q} !== {1'b1, 1'b0, 4'b1100}) begin
            failures++;
            $display("FAIL hold_valid_end: got rdy=%b qv=%b q=%b want rdy=1 qv=0 q=1100", in_ready, q_valid, q);
        end
        $display("collision hold: q=%b err_cnt=%0d", q, err_cnt);

        // err_clr on the same edge as a mismatch sample.
        fault_en  = 1'b1;
        fault_val = 4'b0000;
        start_req(4'b0001, 1'b1, 2'd1);
        repeat (D) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if ({err, err_cnt} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL clr_vs_set: got err=%b cnt=%0d want err=1 cnt=1", err, err_cnt);
        end
        fault_en = 1'b0;
        $display("collision clr+mismatch: err=%b err_cnt=%0d", err, err_cnt);

        // err_clr alone.
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if ({err, err_cnt} !== 5'd0) begin
            failures++;
            $display("FAIL clr_alone: got err=%b cnt=%0d want 0/0", err, err_cnt);
        end
        $display("err_clr alone: err=%b err_cnt=%0d", err, err_cnt);
    endtask

    task automatic test_reset_mid_sweep();
        start_req(4'b1110, 1'b0, 2'd0);
        repeat (2 * D + 1) @(negedge clk);
        checks++;
        if (sel !== 2'd2) begin
            failures++;
            $display("FAIL midsweep_sel: got sel=%0d want 2", sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({q, sel, q_valid, done, in_ready} !== {4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midsweep_reset: got q=%b sel=%0d qv=%b done=%b rdy=%b want 0/0/0/0/1",
                     q, sel, q_valid, done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4 * D; k++) begin
            @(negedge clk);
            checks++;
            if ({done, q_valid, in_ready} !== 3'b001) begin
                failures++;
                $display("FAIL midsweep_nodone%0d: got done=%b qv=%b rdy=%b want 0/0/1", k, done, q_valid, in_ready);
            end
        end
        $display("reset mid-sweep: q=%b sel=%0d done=%b", q, sel, done);
        test_sweep(4'b0101);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_mode = 1'b0; in_sel = 2'd0;
        err_clr = 1'b0; fault_en = 1'b0; fault_val = 4'd0;
        test_reset();
        test_sweep(4'b1011);
        test_single();
        test_fault_saturate();
        test_collisions();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
